// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronised line, mid-bit sampling, LSB first.
// Emits a one-cycle o_vld with the received byte, or a one-cycle o_err on a low stop bit.
module uart_rx #(
  parameter int FREQ = 50_000_000,
  parameter int RATE = 2_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_vld,
  output logic       o_err
);

  localparam int DIV  = FREQ / RATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;
  logic          rx_meta_q, rx_s_q;

  // The line is asynchronous; reset both flops to the idle-high level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  // The counter free-runs outside IDLE; every state change clears it.
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE) ? '0 : cnt_q + CNT_ONE;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = '0;
          end
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            vld_d   = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_data = data_q;
  assign o_vld  = vld_q;
  assign o_err  = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of directed frames, hand-written glitch/reset sequences,
// then random frames checked against a frame-level expectation model.
module tb_uart_rx;

  localparam int FREQ = 50_000_000;
  localparam int RATE = 2_000_000;
  localparam int DIV  = FREQ / RATE;
  localparam int HALF = DIV / 2;
  localparam int LAT  = 2 + HALF + 9 * DIV + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_rx = 1'b1;
  logic [7:0] o_data;
  logic       o_vld;
  logic       o_err;

  int vectors = 0;
  int miscompares = 0;
  int cycleCount = 0;
  int startCycle = 0;

  logic [7:0] vldData[$];
  int         vldCyc[$];
  int         errCyc[$];

  typedef struct {
    logic [7:0] data;
    int         period;
    bit         stopGood;
    int         holdLow;
    int         gap;
    bit         expVld;
    logic [7:0] expData;
  } vec_t;

  vec_t table_v[9];

  uart_rx #(.FREQ(FREQ), .RATE(RATE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i_rx  (i_rx),
    .o_data(o_data),
    .o_vld (o_vld),
    .o_err (o_err)
  );

  always #5 clk = ~clk;

  // Record every strobe with its cycle number, sampled just after the edge.
  always @(posedge clk) begin
    cycleCount++;
    #1;
    if (rst_n) begin
      if (o_vld) begin
        vldData.push_back(o_data);
        vldCyc.push_back(cycleCount);
      end
      if (o_err) errCyc.push_back(cycleCount);
      if (o_vld || o_err) checkOutput("vldErrExclusive", int'(o_vld & o_err), 0);
    end
  end

  initial begin
    #900_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    vectors++;
    if (actual < lo || actual > hi) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic driveBit(input bit b, input int n);
    i_rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input int period, input bit stopGood,
                               input int holdLow, input int gap);
    startCycle = cycleCount;
    driveBit(1'b0, period);
    for (int i = 0; i < 8; i++) driveBit(data[i], period);
    driveBit(stopGood, period);
    if (!stopGood) driveBit(1'b0, holdLow);
    driveBit(1'b1, gap);
  endtask

  // expData is the received byte for a good frame, or the value o_data must hold after an error.
  task automatic checkFrame(input bit expVld, input logic [7:0] expData);
    int c;
    logic [7:0] d;
    for (int i = 0; i < 40 && vldCyc.size() == 0 && errCyc.size() == 0; i++) @(negedge clk);
    if (vldCyc.size() == 0 && errCyc.size() == 0) begin
      checkOutput("frameTimeout", 0, 1);
      return;
    end
    checkOutput("vldCount", vldCyc.size(), expVld ? 1 : 0);
    checkOutput("errCount", errCyc.size(), expVld ? 0 : 1);
    if (expVld && vldCyc.size() > 0) begin
      d = vldData.pop_front();
      c = vldCyc.pop_front();
      checkOutput("rxData", int'(d), int'(expData));
      checkRange("vldLatency", c - startCycle, LAT - 1, LAT + 1);
    end
    if (!expVld && errCyc.size() > 0) begin
      c = errCyc.pop_front();
      checkRange("errLatency", c - startCycle, LAT - 1, LAT + 1);
      checkOutput("dataHeld", int'(o_data), int'(expData));
    end
    vldData.delete();
    vldCyc.delete();
    errCyc.delete();
  endtask

  initial begin
    logic [7:0] heldData;
    logic [7:0] rndData;
    int         rndPeriod;
    bit         rndGood;

    table_v[0] = '{8'h5A, 25, 1'b1, 0,   20, 1'b1, 8'h5A};
    table_v[1] = '{8'hA5, 25, 1'b1, 0,   20, 1'b1, 8'hA5};
    table_v[2] = '{8'h00, 25, 1'b1, 0,   0,  1'b1, 8'h00};
    table_v[3] = '{8'hFF, 25, 1'b1, 0,   0,  1'b1, 8'hFF};
    table_v[4] = '{8'h3C, 25, 1'b1, 0,   20, 1'b1, 8'h3C};
    table_v[5] = '{8'hC3, 24, 1'b1, 0,   20, 1'b1, 8'hC3};
    table_v[6] = '{8'hC3, 26, 1'b1, 0,   20, 1'b1, 8'hC3};
    table_v[7] = '{8'h81, 25, 1'b0, 100, 20, 1'b0, 8'hC3};
    table_v[8] = '{8'h81, 25, 1'b1, 0,   20, 1'b1, 8'h81};

    repeat (4) @(negedge clk);
    checkOutput("resetData", int'(o_data), 0);
    checkOutput("resetVld", int'(o_vld), 0);
    checkOutput("resetErr", int'(o_err), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // A short low pulse must be discarded at the mid-start-bit check.
    driveBit(1'b0, 5);
    driveBit(1'b1, 40);
    checkOutput("glitchStrobes", vldCyc.size() + errCyc.size(), 0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(table_v[i].data, table_v[i].period, table_v[i].stopGood,
                    table_v[i].holdLow, table_v[i].gap);
      checkFrame(table_v[i].expVld, table_v[i].expData);
    end

    // Reset in the middle of bit 3 of 0x99 clears outputs immediately.
    driveBit(1'b0, DIV);
    driveBit(1'b1, DIV);
    driveBit(1'b0, DIV);
    driveBit(1'b0, DIV);
    driveBit(1'b1, 10);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midResetData", int'(o_data), 0);
    checkOutput("midResetVld", int'(o_vld), 0);
    checkOutput("midResetErr", int'(o_err), 0);
    i_rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("midResetStrobes", vldCyc.size() + errCyc.size(), 0);
    applyStimulus(8'h7E, 25, 1'b1, 0, 10);
    checkFrame(1'b1, 8'h7E);
    heldData = 8'h7E;

    // Frame-level model: a good stop bit delivers the byte, a bad one flags and holds.
    for (int i = 0; i < 24; i++) begin
      rndData   = 8'($urandom_range(0, 255));
      rndPeriod = $urandom_range(24, 26);
      rndGood   = ($urandom_range(0, 3) != 0);
      applyStimulus(rndData, rndPeriod, rndGood,
                    rndGood ? 0 : $urandom_range(0, 60),
                    rndGood ? $urandom_range(0, 3) : $urandom_range(2, 6));
      if (rndGood) heldData = rndData;
      checkFrame(rndGood, heldData);
    end

    repeat (300) @(negedge clk);
    checkOutput("noStrayStrobes", vldCyc.size() + errCyc.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1 UART receiver, the receive-side counterpart of the team's uart_tx.
- Samples the asynchronous serial line i_rx at mid-bit, LSB first.
- Presents each received byte on o_data with a one-cycle o_vld strobe.
- Flags framing errors on o_err.
- Sits between the board RX pin and byte-level consumers (FIFO, command parser).

Parameters:
FREQ, 50_000_000, system clock frequency in Hz
RATE, 2_000_000, baud rate in bit/s; DIV = FREQ/RATE (integer division, DIV >= 4 required), HALF = DIV/2

Ports:
clk     input   1  system clock, all logic on posedge
rst_n   input   1  asynchronous active-low reset
i_rx    input   1  serial line, asynchronous to clk, idles high
o_data  output  8  last correctly received byte; held until next valid frame
o_vld   output  1  one-cycle strobe: o_data updated this cycle
o_err   output  1  one-cycle strobe: stop bit sampled low (framing error)

Behaviour:
- Reset is asynchronous, active-low, applied to all flops.
- Reset values: o_data=8'h00, o_vld=0, o_err=0, state=IDLE, synchronizer flops=1, bit counter=0.
- Synchronizer: i_rx passes through two flops giving rx_s. All decisions use rx_s only; i_rx is never used directly.
- Baud counter: width $clog2(DIV), cleared on every state entry, increments every cycle outside IDLE.
- FSM states: IDLE, START, DATA (3-bit bit index 0..7), STOP, WAIT_HIGH.
- IDLE: rx_s==0 -> START, counter cleared.
- START: when counter == HALF-1, sample rx_s.
  - rx_s==1: glitch -> IDLE, no strobe.
  - rx_s==0: -> DATA with index=0, counter cleared.
- DATA: when counter == DIV-1, sample rx_s into shift register bit [index] (LSB first) and clear counter.
  - index==7: -> STOP.
  - Otherwise index+1.
- STOP: when counter == DIV-1, sample rx_s.
  - rx_s==1: o_data <= shift register, o_vld=1 for exactly the next cycle, -> IDLE.
  - rx_s==0: o_err=1 for exactly the next cycle, o_data unchanged, -> WAIT_HIGH.
- WAIT_HIGH: stays until rx_s==1, then -> IDLE. A held-low break line produces exactly one o_err and no further activity.
- o_vld and o_err are never asserted in the same cycle.
- o_vld and o_err are registered outputs (no combinational path from i_rx).
- Latency: the o_vld rising edge occurs 2 + HALF + 9*DIV + 1 cycles after the i_rx falling edge of the start bit, ±1 cycle of synchronizer phase. For the defaults this is 240 cycles.
- Back-to-back frames: the first cycle of IDLE after STOP already detects the next start bit. No idle gap is required between frames.
- Reset mid-frame: the partial frame is discarded, no strobe is generated, and the block restarts in IDLE. A low line after reset release is treated as a new start bit.
- Baud tolerance: correct reception for a transmitter rate error up to ±3% at DIV >= 16.

Test Plan:
- Single byte: FREQ=50M, RATE=2M (DIV=25). Drive 8N1 frame 0xA5 with 25-cycle bits -> o_vld high exactly 1 cycle, 240±1 cycles after the start edge, o_data=8'hA5, o_err never high.
- Back-to-back: drive 0x00, 0xFF, 0x3C with no idle gap -> three o_vld pulses 250±1 cycles apart, o_data 8'h00, 8'hFF, 8'h3C in order.
- Glitch rejection: pulse i_rx low for 5 cycles then high -> no o_vld, no o_err. A following valid 0x5A frame is received correctly.
- Framing error: drive 0x81 with the stop bit low, then hold low 100 cycles, then high -> one o_err pulse and no o_vld. o_data keeps its previous value. A subsequent 0x81 with a good stop bit -> o_vld with o_data=8'h81.
- Reset mid-frame: assert rst_n low during bit 3 of a frame -> o_data=0, o_vld=0, o_err=0 immediately (asynchronous). After release with the line idle high, a 0x7E frame -> o_data=8'h7E.
- Rate skew: transmit 0xC3 at 24- and 26-cycle bit periods (±4%) -> o_data=8'hC3 with o_vld and no o_err in both cases.
